// File: rtl/game_countdown_ready.sv
// ---------------------------------------------------------------------------
// game_countdown_ready
//
// Pre-game "READY" prompt. While start_game_i is held high it scans the
// letters R-E-A-D-Y across the seven-segment digits and fills an LED
// progress bar over COUNT_SEC seconds. When the countdown finishes it
// raises ready_game_o and strobes ready_pulse_o for one cycle. If
// start_game_i drops at any point, the block returns to idle.
//
// Parameters
//   CLK_HZ    input clock frequency in Hz
//   SCAN_HZ   digit-slot advance rate (CLK_HZ/SCAN_HZ cycles per slot)
//   COUNT_SEC prompt length in seconds (1..9)
//   LED_W     LED bar width (1..16)
//
// Ports
//   clk_i             system clock
//   rst_ni            asynchronous active-low reset
//   start_game_i      high requests and holds the prompt
//   dig_display_o     one-hot digit enables
//   seg_code_1_o      segments for digits 7:4, {dp,g,f,e,d,c,b,a}
//   seg_code_2_o      segments for digits 3:0, same encoding
//   state_led_show_o  progress bar, MSB fills first
//   ready_game_o      level, prompt completed
//   ready_pulse_o     one-cycle strobe on completion
//
// Build option
//   GAME_READY_DIGIT_EN  adds a sixth slot showing the remaining seconds
//                        on digit 0.
//
// state | meaning
// IDLE  | waiting for start_game_i, all outputs 0
// RUN   | scanning READY and filling the bar
// DONE  | countdown finished, ready_game_o high, display dark
// ---------------------------------------------------------------------------
module game_countdown_ready #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int COUNT_SEC = 3,
  parameter int LED_W     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_game_i,
  output logic [7:0]       dig_display_o,
  output logic [7:0]       seg_code_1_o,
  output logic [7:0]       seg_code_2_o,
  output logic [LED_W-1:0] state_led_show_o,
  output logic             ready_game_o,
  output logic             ready_pulse_o
);

  localparam int TOTAL    = COUNT_SEC * CLK_HZ;
  localparam int SCAN_CYC = CLK_HZ / SCAN_HZ;
  localparam int STEP_CYC = TOTAL / LED_W;
  localparam int CW = (TOTAL > 1)    ? $clog2(TOTAL)    : 1;
  localparam int PW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int LW = (LED_W > 1)    ? $clog2(LED_W)    : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TOTAL - 1);
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_CYC - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
  localparam logic [LW-1:0] LED_LAST  = LW'(LED_W - 1);
`ifdef GAME_READY_DIGIT_EN
  localparam logic [2:0] SLOT_LAST = 3'd5;
  localparam int SECW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [SECW-1:0] SEC_LAST = SECW'(CLK_HZ - 1);
`else
  localparam logic [2:0] SLOT_LAST = 3'd4;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        slot_q, slot_d;
  logic [SW-1:0]     step_q, step_d;
  // Index of the lowest lit LED counted from the MSB (lit LEDs = led_n + 1).
  logic [LW-1:0]     led_n_q, led_n_d;
  logic [7:0]        dig_q, dig_d, seg1_q, seg1_d, seg2_q, seg2_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              ready_game_q, ready_game_d, ready_pulse_q, ready_pulse_d;
`ifdef GAME_READY_DIGIT_EN
  logic [SECW-1:0]   secp_q, secp_d;
  logic [3:0]        sec_q, sec_d;
  logic [3:0]        remain;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 8'h3F;
      4'd1:    seg_digit = 8'h06;
      4'd2:    seg_digit = 8'h5B;
      4'd3:    seg_digit = 8'h4F;
      4'd4:    seg_digit = 8'h66;
      4'd5:    seg_digit = 8'h6D;
      4'd6:    seg_digit = 8'h7D;
      4'd7:    seg_digit = 8'h07;
      4'd8:    seg_digit = 8'h7F;
      4'd9:    seg_digit = 8'h6F;
      default: seg_digit = 8'h00;
    endcase
  endfunction

  assign remain = 4'(COUNT_SEC) - sec_q;
`endif

  // Abort wins over completion on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_game_i) state_d = RUN;
      RUN:     if (!start_game_i) state_d = IDLE;
               else if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    if (!start_game_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All counters run only in RUN; any other state clears them, so every
  // entry into RUN starts from zero.
  always_comb begin
    cnt_d   = '0;
    pre_d   = '0;
    slot_d  = '0;
    step_d  = '0;
    led_n_d = '0;
`ifdef GAME_READY_DIGIT_EN
    secp_d  = '0;
    sec_d   = '0;
`endif
    if (state_q == RUN) begin
      cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
      if (pre_q == SCAN_LAST) begin
        slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
      end else begin
        pre_d  = pre_q + PW'(1);
        slot_d = slot_q;
      end
      if (step_q == STEP_LAST) begin
        led_n_d = (led_n_q == LED_LAST) ? led_n_q : led_n_q + LW'(1);
      end else begin
        step_d  = step_q + SW'(1);
        led_n_d = led_n_q;
      end
`ifdef GAME_READY_DIGIT_EN
      if (secp_q == SEC_LAST) begin
        sec_d = sec_q + 4'd1;
      end else begin
        secp_d = secp_q + SECW'(1);
        sec_d  = sec_q;
      end
`endif
    end
  end

  always_comb begin
    dig_d  = '0;
    seg1_d = '0;
    seg2_d = '0;
    led_d  = '0;
    if (state_q == RUN) begin
      case (slot_q)
        3'd0: begin dig_d = 8'h40; seg1_d = 8'h77; end
        3'd1: begin dig_d = 8'h20; seg1_d = 8'h79; end
        3'd2: begin dig_d = 8'h10; seg1_d = 8'h77; end
        3'd3: begin dig_d = 8'h08; seg2_d = 8'h3F; end
        3'd4: begin dig_d = 8'h04; seg2_d = 8'h6E; end
`ifdef GAME_READY_DIGIT_EN
        3'd5: begin dig_d = 8'h01; seg2_d = seg_digit(remain); end
`endif
        default: ;
      endcase
      for (int i = 0; i < LED_W; i++) begin
        led_d[LED_W-1-i] = (i <= int'(led_n_q));
      end
    end
    // ready rises with the RUN->DONE transition and is held through the
    // edge that leaves DONE, so it falls one cycle after the abort edge.
    ready_pulse_d = (state_q == RUN) && (state_d == DONE);
    ready_game_d  = (state_q == DONE) || ready_pulse_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pre_q         <= '0;
      slot_q        <= '0;
      step_q        <= '0;
      led_n_q       <= '0;
      dig_q         <= '0;
      seg1_q        <= '0;
      seg2_q        <= '0;
      led_q         <= '0;
      ready_game_q  <= 1'b0;
      ready_pulse_q <= 1'b0;
`ifdef GAME_READY_DIGIT_EN
      secp_q        <= '0;
      sec_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pre_q         <= pre_d;
      slot_q        <= slot_d;
      step_q        <= step_d;
      led_n_q       <= led_n_d;
      dig_q         <= dig_d;
      seg1_q        <= seg1_d;
      seg2_q        <= seg2_d;
      led_q         <= led_d;
      ready_game_q  <= ready_game_d;
      ready_pulse_q <= ready_pulse_d;
`ifdef GAME_READY_DIGIT_EN
      secp_q        <= secp_d;
      sec_q         <= sec_d;
`endif
    end
  end

  assign dig_display_o    = dig_q;
  assign seg_code_1_o     = seg1_q;
  assign seg_code_2_o     = seg2_q;
  assign state_led_show_o = led_q;
  assign ready_game_o     = ready_game_q;
  assign ready_pulse_o    = ready_pulse_q;

endmodule

// File: tb/tb_game_countdown_ready.sv
module tb_game_countdown_ready;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dig, s1, s2;
  logic [3:0] led;
  logic       rg, rp;

  game_countdown_ready #(
    .CLK_HZ(40), .SCAN_HZ(10), .COUNT_SEC(2), .LED_W(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_game_i(start),
    .dig_display_o(dig),
    .seg_code_1_o(s1),
    .seg_code_2_o(s2),
    .state_led_show_o(led),
    .ready_game_o(rg),
    .ready_pulse_o(rp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef GAME_READY_DIGIT_EN
  localparam int NS = 6;
`else
  localparam int NS = 5;
`endif

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] dig;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [3:0] led;
    logic       rg;
    logic       rp;
  } exp_t;

  exp_t  q[$];
  int    pq[$];
  int    last_cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  string tag = "reset";
  logic [7:0] digs [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                            8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  function automatic exp_t zero_exp(int c, logic rgv, string t);
    exp_t e;
    e.cyc = c; e.tag = t;
    e.dig = 8'h00; e.s1 = 8'h00; e.s2 = 8'h00; e.led = 4'h0;
    e.rg = rgv; e.rp = 1'b0;
    return e;
  endfunction

  // Output seen at edge k+m of a countdown whose start was sampled at edge k.
  function automatic exp_t run_exp(int c, int m, logic fin, string t);
    exp_t e;
    int slot, lit;
    logic [3:0] all1 = 4'hF;
    e = zero_exp(c, 1'b0, t);
    slot = ((m - 1) / 4) % NS;
    lit  = 1 + (m - 1) / 20;
    if (lit > 4) lit = 4;
    e.led = ~(all1 >> lit);
    case (slot)
      0: begin e.dig = 8'h40; e.s1 = 8'h77; end
      1: begin e.dig = 8'h20; e.s1 = 8'h79; end
      2: begin e.dig = 8'h10; e.s1 = 8'h77; end
      3: begin e.dig = 8'h08; e.s2 = 8'h3F; end
      4: begin e.dig = 8'h04; e.s2 = 8'h6E; end
      default: begin e.dig = 8'h01; e.s2 = digs[2 - (m - 1) / 40]; end
    endcase
    e.rg = fin && (m == 80);
    e.rp = fin && (m == 80);
    return e;
  endfunction

  task automatic push_e(input exp_t e);
    if (e.cyc > last_cyc) begin
      q.push_back(e);
      last_cyc = e.cyc;
    end
  endtask

  // Expectations for a countdown sampled at edge k, with start seen low at
  // edge k+drop_m (drop_m > 80 means it completed first).
  task automatic push_count(input int k, input int drop_m);
    push_e(zero_exp(k, 1'b0, tag));
    for (int m = 1; m <= drop_m; m++) begin
      if (m <= 80) push_e(run_exp(k + m, m, drop_m > 80, tag));
      else         push_e(zero_exp(k + m, 1'b1, tag));
    end
    push_e(zero_exp(k + drop_m + 1, 1'b0, tag));
    if (drop_m > 80) pq.push_back(k + 80);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      push_e(zero_exp(cyc + 1, 1'b0, tag));
    end
  endtask

  task automatic countdown(input int drop_m);
    int k;
    tick();
    start = 1'b1;
    k = cyc + 1;
    push_count(k, drop_m);
    repeat (drop_m) tick();
    start = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc < cyc)
        $display("FAIL %s cyc %0d: expectation skipped (now cyc %0d)", e.tag, e.cyc, cyc);
      else if ({dig, s1, s2, led, rg, rp} !== {e.dig, e.s1, e.s2, e.led, e.rg, e.rp})
        $display("FAIL %s cyc %0d: got dig=%h s1=%h s2=%h led=%b rg=%b rp=%b, need dig=%h s1=%h s2=%h led=%b rg=%b rp=%b",
                 e.tag, cyc, dig, s1, s2, led, rg, rp, e.dig, e.s1, e.s2, e.led, e.rg, e.rp);
      else
        n_pass++;
    end
    if (rp !== 1'b0) begin
      n_checks++;
      if (pq.size() > 0 && pq[0] == cyc) begin
        void'(pq.pop_front());
        n_pass++;
      end else begin
        $display("FAIL pulse cyc %0d: ready_pulse=%b, need 0", cyc, rp);
      end
    end
  end

  initial begin
    int k, k2;
    rst_n = 1'b0;
    for (int c = 1; c <= 3; c++) push_e(zero_exp(c, 1'b0, tag));
    repeat (3) tick();
    rst_n = 1'b1;

    tag = "idle50";
    idle(50);

    tag = "full";
    countdown(90);
    idle(5);

    tag = "abort50";
    countdown(50);
    idle(9);
    tag = "reraise";
    countdown(90);
    idle(5);

    tag = "abort_at_done";
    countdown(80);
    idle(5);

    tag = "glitch";
    countdown(30);
    tag = "glitch_restart";
    countdown(90);
    idle(5);

    tag = "rst_mid";
    tick();
    start = 1'b1;
    k = cyc + 1;
    push_count(k, 30);
    repeat (31) tick();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tag = "rst_restart";
    k2 = k + 31;
    push_count(k2, 85);
    repeat (85) tick();
    start = 1'b0;
    idle(5);

    repeat (3) tick();
    while (q.size() > 0) begin
      n_checks++;
      $display("FAIL %s cyc %0d: expectation never checked", q[0].tag, q[0].cyc);
      void'(q.pop_front());
    end
    while (pq.size() > 0) begin
      n_checks++;
      $display("FAIL pulse cyc %0d: ready_pulse=0, need 1", pq[0]);
      void'(pq.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
